// File: rtl/if_stage.sv
// MIPS instruction fetch plus IF/ID register: one-cycle fetch-to-ID latency, imem read combinational in the same cycle.
// Backpressure: stall holds PC and IF/ID; EX redirect overrides stall, bubbles IF/ID and raises id_flush for ID/EX.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        EX_redirect,
    input  logic [31:0] EX_target,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_pc_plus4,
    output logic [31:0] ID_inst,
    output logic        ID_valid,
    output logic        id_flush,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign id_flush  = EX_redirect;

    // Redirect beats stall: the stalled instruction is on the wrong path anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            ID_pc       <= '0;
            ID_pc_plus4 <= '0;
            ID_inst     <= NOP_INST;
            ID_valid    <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else if (EX_redirect) begin
            pc          <= {EX_target[31:2], 2'b00};
            ID_pc       <= '0;
            ID_pc_plus4 <= '0;
            ID_inst     <= NOP_INST;
            ID_valid    <= 1'b0;
            if (EX_target[1:0] != 2'b00)
                misalign <= 1'b1;
        end else if (!stall) begin
            pc          <= pc_plus4;
            ID_pc       <= pc;
            ID_pc_plus4 <= pc_plus4;
            ID_inst     <= imem_rdata;
            ID_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: main instance at the default reset PC, second instance exercising PC wrap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, EX_redirect;
    logic [31:0] EX_target, imem_rdata;
    logic [31:0] imem_addr, ID_pc, ID_pc_plus4, ID_inst, fetch_count;
    logic        ID_valid, id_flush, misalign;

    logic        rst_w, stall_w, redir_w;
    logic [31:0] target_w, rdata_w;
    logic [31:0] addr_w, pc_w, pc4_w, inst_w, count_w;
    logic        valid_w, flush_w, mis_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .EX_redirect(EX_redirect), .EX_target(EX_target),
        .ID_pc(ID_pc), .ID_pc_plus4(ID_pc_plus4), .ID_inst(ID_inst),
        .ID_valid(ID_valid), .id_flush(id_flush), .misalign(misalign),
        .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
        .stall(stall_w), .EX_redirect(redir_w), .EX_target(target_w),
        .ID_pc(pc_w), .ID_pc_plus4(pc4_w), .ID_inst(inst_w),
        .ID_valid(valid_w), .id_flush(flush_w), .misalign(mis_w),
        .fetch_count(count_w)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst_w = 1'b1;
        stall = 1'b0; EX_redirect = 1'b0; EX_target = '0; imem_rdata = '0;
        stall_w = 1'b0; redir_w = 1'b0; target_w = '0; rdata_w = 32'hAAAA_0000;
        #1;
        rst = 1'b0; rst_w = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL reset_pc got %h want %h", imem_addr, 32'h3000); end
        total++; if (ID_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc got %h want 0", ID_pc); end
        total++; if (ID_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_id_pc4 got %h want 0", ID_pc_plus4); end
        total++; if (ID_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got %h want 0", ID_inst); end
        total++; if (ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", ID_valid); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got %b want 0", misalign); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got %h want 0", fetch_count); end
        total++; if (id_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got %b want 0", id_flush); end
        step; step;
        total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL reset_hold got %h want %h", imem_addr, 32'h3000); end
        rst = 1'b1;
    endtask

    task automatic test_advance;
        imem_rdata = 32'h11; step;
        total++; if (ID_pc !== 32'h3000) begin bad++; $display("FAIL adv1_pc got %h want %h", ID_pc, 32'h3000); end
        total++; if (ID_pc_plus4 !== 32'h3004) begin bad++; $display("FAIL adv1_pc4 got %h want %h", ID_pc_plus4, 32'h3004); end
        total++; if (ID_inst !== 32'h11) begin bad++; $display("FAIL adv1_inst got %h want %h", ID_inst, 32'h11); end
        total++; if (ID_valid !== 1'b1) begin bad++; $display("FAIL adv1_valid got %b want 1", ID_valid); end
        total++; if (imem_addr !== 32'h3004) begin bad++; $display("FAIL adv1_addr got %h want %h", imem_addr, 32'h3004); end
        imem_rdata = 32'h22; step;
        total++; if (ID_pc !== 32'h3004) begin bad++; $display("FAIL adv2_pc got %h want %h", ID_pc, 32'h3004); end
        total++; if (ID_inst !== 32'h22) begin bad++; $display("FAIL adv2_inst got %h want %h", ID_inst, 32'h22); end
        imem_rdata = 32'h33; step;
        total++; if (ID_pc !== 32'h3008) begin bad++; $display("FAIL adv3_pc got %h want %h", ID_pc, 32'h3008); end
        total++; if (ID_inst !== 32'h33) begin bad++; $display("FAIL adv3_inst got %h want %h", ID_inst, 32'h33); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL adv3_count got %0d want 3", fetch_count); end
        total++; if (imem_addr !== 32'h300C) begin bad++; $display("FAIL adv3_addr got %h want %h", imem_addr, 32'h300C); end
    endtask

    task automatic test_stall;
        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step;
            total++; if (imem_addr !== 32'h300C) begin bad++; $display("FAIL stall_addr cyc%0d got %h want %h", i, imem_addr, 32'h300C); end
            total++; if (ID_pc !== 32'h3008) begin bad++; $display("FAIL stall_id_pc cyc%0d got %h want %h", i, ID_pc, 32'h3008); end
            total++; if (ID_inst !== 32'h33) begin bad++; $display("FAIL stall_inst cyc%0d got %h want %h", i, ID_inst, 32'h33); end
            total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_count cyc%0d got %0d want 3", i, fetch_count); end
        end
        stall = 1'b0; imem_rdata = 32'h44; step;
        total++; if (ID_pc !== 32'h300C) begin bad++; $display("FAIL unstall_pc got %h want %h", ID_pc, 32'h300C); end
        total++; if (ID_inst !== 32'h44) begin bad++; $display("FAIL unstall_inst got %h want %h", ID_inst, 32'h44); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL unstall_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_redirect_stall;
        stall = 1'b1; EX_redirect = 1'b1; EX_target = 32'h3400;
        #1;
        total++; if (id_flush !== 1'b1) begin bad++; $display("FAIL redir_flush got %b want 1", id_flush); end
        step;
        total++; if (imem_addr !== 32'h3400) begin bad++; $display("FAIL redir_addr got %h want %h", imem_addr, 32'h3400); end
        total++; if (ID_inst !== 32'h0) begin bad++; $display("FAIL redir_inst got %h want 0", ID_inst); end
        total++; if (ID_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got %b want 0", ID_valid); end
        total++; if (ID_pc !== 32'h0) begin bad++; $display("FAIL redir_id_pc got %h want 0", ID_pc); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL redir_count got %0d want 4", fetch_count); end
        stall = 1'b0; EX_redirect = 1'b0; imem_rdata = 32'h55; step;
        total++; if (ID_pc !== 32'h3400) begin bad++; $display("FAIL target_pc got %h want %h", ID_pc, 32'h3400); end
        total++; if (ID_pc_plus4 !== 32'h3404) begin bad++; $display("FAIL target_pc4 got %h want %h", ID_pc_plus4, 32'h3404); end
        total++; if (ID_inst !== 32'h55) begin bad++; $display("FAIL target_inst got %h want %h", ID_inst, 32'h55); end
        total++; if (id_flush !== 1'b0) begin bad++; $display("FAIL target_flush got %b want 0", id_flush); end
        total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL target_count got %0d want 5", fetch_count); end
    endtask

    task automatic test_misalign;
        EX_redirect = 1'b1; EX_target = 32'h3402; step;
        EX_redirect = 1'b0;
        total++; if (imem_addr !== 32'h3400) begin bad++; $display("FAIL mis_addr got %h want %h", imem_addr, 32'h3400); end
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got %b want 1", misalign); end
        for (int i = 0; i < 10; i++) begin
            imem_rdata = 32'h100 + i; step;
        end
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky got %b want 1", misalign); end
        total++; if (imem_addr !== 32'h3428) begin bad++; $display("FAIL mis_run_addr got %h want %h", imem_addr, 32'h3428); end
        total++; if (ID_pc !== 32'h3424) begin bad++; $display("FAIL mis_run_pc got %h want %h", ID_pc, 32'h3424); end
        total++; if (fetch_count !== 32'd15) begin bad++; $display("FAIL mis_run_count got %0d want 15", fetch_count); end
    endtask

    task automatic test_back_to_back;
        EX_redirect = 1'b1; EX_target = 32'h4000; step;
        EX_target = 32'h5000; step;
        EX_redirect = 1'b0;
        total++; if (imem_addr !== 32'h5000) begin bad++; $display("FAIL b2b_addr got %h want %h", imem_addr, 32'h5000); end
        total++; if (ID_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got %b want 0", ID_valid); end
        total++; if (fetch_count !== 32'd15) begin bad++; $display("FAIL b2b_count got %0d want 15", fetch_count); end
        imem_rdata = 32'h66; step;
        total++; if (ID_pc !== 32'h5000) begin bad++; $display("FAIL b2b_id_pc got %h want %h", ID_pc, 32'h5000); end
        total++; if (ID_inst !== 32'h66) begin bad++; $display("FAIL b2b_inst got %h want %h", ID_inst, 32'h66); end
        total++; if (fetch_count !== 32'd16) begin bad++; $display("FAIL b2b_count2 got %0d want 16", fetch_count); end
    endtask

    task automatic test_async_reset;
        stall = 1'b1; step; step;
        total++; if (ID_pc !== 32'h5000) begin bad++; $display("FAIL pre_arst_pc got %h want %h", ID_pc, 32'h5000); end
        #3;
        rst = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL arst_addr got %h want %h", imem_addr, 32'h3000); end
        total++; if (ID_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", ID_valid); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL arst_count got %0d want 0", fetch_count); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL arst_misalign got %b want 0", misalign); end
        total++; if (ID_pc !== 32'h0) begin bad++; $display("FAIL arst_id_pc got %h want 0", ID_pc); end
        step;
        rst = 1'b1; stall = 1'b0; imem_rdata = 32'h77; step;
        total++; if (ID_pc !== 32'h3000) begin bad++; $display("FAIL restart_pc got %h want %h", ID_pc, 32'h3000); end
        total++; if (ID_inst !== 32'h77) begin bad++; $display("FAIL restart_inst got %h want %h", ID_inst, 32'h77); end
        total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL restart_count got %0d want 1", fetch_count); end
        total++; if (imem_addr !== 32'h3004) begin bad++; $display("FAIL restart_addr got %h want %h", imem_addr, 32'h3004); end
    endtask

    task automatic test_wrap;
        total++; if (addr_w !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_reset got %h want %h", addr_w, 32'hFFFF_FFF8); end
        rst_w = 1'b1; step;
        total++; if (pc_w !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap1_pc got %h want %h", pc_w, 32'hFFFF_FFF8); end
        total++; if (pc4_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap1_pc4 got %h want %h", pc4_w, 32'hFFFF_FFFC); end
        step;
        total++; if (pc_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap2_pc got %h want %h", pc_w, 32'hFFFF_FFFC); end
        total++; if (pc4_w !== 32'h0) begin bad++; $display("FAIL wrap2_pc4 got %h want 0", pc4_w); end
        step;
        total++; if (pc_w !== 32'h0) begin bad++; $display("FAIL wrap3_pc got %h want 0", pc_w); end
        total++; if (addr_w !== 32'h4) begin bad++; $display("FAIL wrap3_addr got %h want 4", addr_w); end
        total++; if (count_w !== 32'd3) begin bad++; $display("FAIL wrap3_count got %0d want 3", count_w); end
    endtask

    initial begin
        test_reset;
        test_advance;
        test_stall;
        test_redirect_stall;
        test_misalign;
        test_back_to_back;
        test_async_reset;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
